// File: rtl/legv8_decode_ctrl_pkg.sv
// Shared LEGv8 decode constants: ALU op codes, opcode patterns
// and the control bundle handed from decode to execute.
package legv8_decode_ctrl_pkg;

   localparam int IMM_W  = 64;
   localparam int WORD_W = 32;

   localparam logic [3:0] ALU_OP_AND = 4'b0000;
   localparam logic [3:0] ALU_OP_ORR = 4'b0001;
   localparam logic [3:0] ALU_OP_ADD = 4'b0010;
   localparam logic [3:0] ALU_OP_SUB = 4'b0110;
   localparam logic [3:0] ALU_OP_CPZ = 4'b0111;

   localparam logic [10:0] OPC_ADD  = 11'b10001011000;
   localparam logic [10:0] OPC_SUB  = 11'b11001011000;
   localparam logic [10:0] OPC_AND  = 11'b10001010000;
   localparam logic [10:0] OPC_ORR  = 11'b10101010000;
   localparam logic [10:0] OPC_LDUR = 11'b11111000010;
   localparam logic [10:0] OPC_STUR = 11'b11111000000;
   localparam logic [9:0]  OPC_ADDI = 10'b1001000100;
   localparam logic [9:0]  OPC_SUBI = 10'b1101000100;
   localparam logic [7:0]  OPC_CBZ  = 8'b10110100;
   localparam logic [5:0]  OPC_B    = 6'b000101;

   typedef struct packed {
      logic [3:0]       alu_op;
      logic             alu_src;
      logic [IMM_W-1:0] imm;
      logic [4:0]       rn;
      logic [4:0]       rm;
      logic [4:0]       rd;
      logic             reg_write;
      logic             mem_read;
      logic             mem_write;
      logic             zero_branch;
      logic             uncond_branch;
      logic             illegal;
   } ctrl_t;

endpackage

// File: rtl/legv8_decode_comb.sv
// Pure combinational LEGv8 instruction -> control bundle decoder.
// Opcode classes are mutually exclusive, so a parallel match suffices.
module legv8_decode_comb
   import legv8_decode_ctrl_pkg::*;
(
   input  logic [WORD_W-1:0] insn,
   output ctrl_t             ctrl
);

   logic is_add, is_sub, is_and, is_orr;
   logic is_ldur, is_stur, is_addi, is_subi;
   logic is_cbz, is_b;

   assign is_add  = insn[31:21] == OPC_ADD;
   assign is_sub  = insn[31:21] == OPC_SUB;
   assign is_and  = insn[31:21] == OPC_AND;
   assign is_orr  = insn[31:21] == OPC_ORR;
   assign is_ldur = insn[31:21] == OPC_LDUR;
   assign is_stur = insn[31:21] == OPC_STUR;
   assign is_addi = insn[31:22] == OPC_ADDI;
   assign is_subi = insn[31:22] == OPC_SUBI;
   assign is_cbz  = insn[31:24] == OPC_CBZ;
   assign is_b    = insn[31:26] == OPC_B;

   always_comb begin
      ctrl        = '0;
      ctrl.alu_op = ALU_OP_AND;
      ctrl.rn     = insn[9:5];
      ctrl.rm     = insn[20:16];
      ctrl.rd     = insn[4:0];
      unique case (1'b1)
         is_add: begin
            ctrl.alu_op    = ALU_OP_ADD;
            ctrl.reg_write = 1'b1;
         end
         is_sub: begin
            ctrl.alu_op    = ALU_OP_SUB;
            ctrl.reg_write = 1'b1;
         end
         is_and: ctrl.reg_write = 1'b1;
         is_orr: begin
            ctrl.alu_op    = ALU_OP_ORR;
            ctrl.reg_write = 1'b1;
         end
         is_ldur: begin
            ctrl.alu_op    = ALU_OP_ADD;
            ctrl.alu_src   = 1'b1;
            ctrl.imm       = IMM_W'($signed(insn[20:12]));
            ctrl.mem_read  = 1'b1;
            ctrl.reg_write = 1'b1;
         end
         is_stur: begin
            ctrl.alu_op    = ALU_OP_ADD;
            ctrl.alu_src   = 1'b1;
            ctrl.imm       = IMM_W'($signed(insn[20:12]));
            ctrl.mem_write = 1'b1;
            ctrl.rm        = insn[4:0];
         end
         is_addi: begin
            ctrl.alu_op    = ALU_OP_ADD;
            ctrl.alu_src   = 1'b1;
            ctrl.imm       = IMM_W'(insn[21:10]);
            ctrl.reg_write = 1'b1;
         end
         is_subi: begin
            ctrl.alu_op    = ALU_OP_SUB;
            ctrl.alu_src   = 1'b1;
            ctrl.imm       = IMM_W'(insn[21:10]);
            ctrl.reg_write = 1'b1;
         end
         is_cbz: begin
            ctrl.alu_op      = ALU_OP_CPZ;
            ctrl.rm          = insn[4:0];
            ctrl.imm         = IMM_W'($signed(insn[23:5]));
            ctrl.zero_branch = 1'b1;
         end
         is_b: begin
            ctrl.imm           = IMM_W'($signed(insn[25:0]));
            ctrl.uncond_branch = 1'b1;
         end
         default: ctrl.illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/legv8_decode_ctrl.sv
// Decode stage: registered control bundle plus one skid entry so
// in_ready depends only on local state, never on out_ready.
module legv8_decode_ctrl
   import legv8_decode_ctrl_pkg::*;
#(
   parameter int XLEN   = 64,
   parameter int INSN_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [INSN_W-1:0] in_insn,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [3:0]        alu_op,
   output logic              alu_src,
   output logic [XLEN-1:0]   imm,
   output logic [4:0]        rn,
   output logic [4:0]        rm,
   output logic [4:0]        rd,
   output logic              reg_write,
   output logic              mem_read,
   output logic              mem_write,
   output logic              zero_branch,
   output logic              uncond_branch,
   output logic              illegal
);

   ctrl_t dec;
   ctrl_t out_q;
   ctrl_t skid_q;
   logic  out_v;
   logic  skid_full;
   logic  acc;
   logic  drain;

   legv8_decode_comb u_comb (
      .insn (in_insn),
      .ctrl (dec)
   );

   assign in_ready = !skid_full;
   assign acc      = in_valid && in_ready;
   assign drain    = out_v && out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_v     <= 1'b0;
         skid_full <= 1'b0;
         out_q     <= '0;
         skid_q    <= '0;
      end else if (flush) begin
         out_v     <= 1'b0;
         skid_full <= 1'b0;
      end else if (!out_v || drain) begin
         // skid is older than anything arriving now (in_ready was low)
         if (skid_full) begin
            out_q     <= skid_q;
            out_v     <= 1'b1;
            skid_full <= 1'b0;
         end else begin
            out_v <= acc;
            if (acc) out_q <= dec;
         end
      end else if (acc) begin
         skid_q    <= dec;
         skid_full <= 1'b1;
      end
   end

   assign out_valid     = out_v;
   assign alu_op        = out_q.alu_op;
   assign alu_src       = out_q.alu_src;
   assign imm           = out_q.imm;
   assign rn            = out_q.rn;
   assign rm            = out_q.rm;
   assign rd            = out_q.rd;
   assign reg_write     = out_q.reg_write;
   assign mem_read      = out_q.mem_read;
   assign mem_write     = out_q.mem_write;
   assign zero_branch   = out_q.zero_branch;
   assign uncond_branch = out_q.uncond_branch;
   assign illegal       = out_q.illegal;

endmodule
